// File: rtl/rom_port_arbiter.sv
`timescale 1ns/1ps
// rom_port_arbiter
//
// Shares the single instruction ROM between the fetch stage (IF port) and a
// data-side reader (DM port). Every access goes through a fixed two-stage
// pipeline:
//   cycle N   : request granted (combinational grant)
//   cycle N+1 : rom_ce/rom_addr registered and presented to the ROM
//   cycle N+2 : ROM data registered into the owner's *_rdata, *_rvalid pulses
//
// Handshake: a requester holds *_req with a stable *_addr until it sees
// *_gnt high in the same cycle. The request is accepted on that clock edge.
// Responses carry no backpressure: *_rvalid is a one-cycle pulse and the
// requester must take *_rdata on that cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_req/if_addr        fetch request and word address
//   if_flush              kills the fetch in stage 1 and blocks fetch grants
//   if_gnt                fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata    fetch response (registered)
//   dm_req/dm_addr        data-side read request and word address
//   dm_gnt                data read accepted this cycle (combinational)
//   dm_rvalid/dm_rdata    data-side response (registered)
//   rom_ce/rom_addr       ROM enable and address (registered)
//   rom_inst              ROM read data, combinational from rom_ce/rom_addr
//   dbg_last_o            round-robin pointer, exposed for checkers
//   dbg_s1_valid_o        stage-1 valid bit, exposed for checkers

module rom_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,

    output logic              dbg_last_o,
    output logic              dbg_s1_valid_o
);

    // Port identity, used both for the round-robin pointer and the
    // stage-1 owner tag.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    owner_e              last_q,      last_d;
    logic                s1_valid_q,  s1_valid_d;
    owner_e              s1_owner_q,  s1_owner_d;
    logic                rom_ce_q,    rom_ce_d;
    logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

    // ------------------------------------------------------------------
    // Grant logic: the only combinational path in the block.
    // ------------------------------------------------------------------
    logic if_elig;
    logic grant_if;
    logic grant_dm;
    logic s1_live;

    always_comb begin
        // A flush blocks new fetches in the same cycle; the fetch path is
        // being redirected, so whatever address it presents is stale.
        if_elig  = if_req & ~if_flush;
        // Under contention the port that did not win last time goes first.
        grant_if = if_elig & (~dm_req | (last_q == OWN_DM));
        grant_dm = dm_req  & (~if_elig | (last_q == OWN_IF));
    end

    assign if_gnt = grant_if;
    assign dm_gnt = grant_dm;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Round-robin pointer moves only on a grant.
        last_d = last_q;
        if (grant_if) begin
            last_d = OWN_IF;
        end else if (grant_dm) begin
            last_d = OWN_DM;
        end

        // Stage 1: the address of the granted port goes to the ROM. On idle
        // cycles the address is held so the ROM input does not toggle.
        s1_valid_d = grant_if | grant_dm;
        rom_ce_d   = grant_if | grant_dm;
        s1_owner_d = s1_owner_q;
        rom_addr_d = rom_addr_q;
        if (grant_if) begin
            s1_owner_d = OWN_IF;
            rom_addr_d = if_addr;
        end else if (grant_dm) begin
            s1_owner_d = OWN_DM;
            rom_addr_d = dm_addr;
        end

        // A fetch sitting in stage 1 during a flush is discarded; the one
        // already in stage 2 (rvalid high now) has been delivered and is
        // unaffected. Data-side entries are never killed.
        s1_live = s1_valid_q & ~((s1_owner_q == OWN_IF) & if_flush);

        // Stage 2: capture ROM data into the owner's response register. The
        // other port's data register keeps its last value.
        if_rvalid_d = s1_live & (s1_owner_q == OWN_IF);
        dm_rvalid_d = s1_live & (s1_owner_q == OWN_DM);
        if_rdata_d  = if_rvalid_d ? rom_inst : if_rdata_q;
        dm_rdata_d  = dm_rvalid_d ? rom_inst : dm_rdata_q;
    end

    // ------------------------------------------------------------------
    // State registers. Reset drops every in-flight entry; the pointer
    // starts at DM so the first contention goes to fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= OWN_DM;
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= OWN_IF;
            rom_ce_q    <= 1'b0;
            rom_addr_q  <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_owner_q  <= s1_owner_d;
            rom_ce_q    <= rom_ce_d;
            rom_addr_q  <= rom_addr_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_ce         = rom_ce_q;
    assign rom_addr       = rom_addr_q;
    assign if_rvalid      = if_rvalid_q;
    assign if_rdata       = if_rdata_q;
    assign dm_rvalid      = dm_rvalid_q;
    assign dm_rdata       = dm_rdata_q;
    assign dbg_last_o     = last_q;
    assign dbg_s1_valid_o = s1_valid_q;

endmodule
